message_scroll_ctrl: RTL and testbench

- Scheduler that sequences the scrolling message display from the 1-cycle tick produced by clock_divider.
- Holds a writable message buffer and a scroll position, and steps the position every 2^speed ticks in the chosen direction.
- Drives the per-digit character codes to the 7-segment decoders.
- Sits between clock_divider (tick source) and the HEX decoder bank.

---
 rtl/msg_display_pkg.sv | 24 ++
 rtl/tick_prescaler.sv | 33 +++
 rtl/message_scroll_ctrl.sv | 114 +++++++++++
 tb/tb_message_scroll_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/msg_display_pkg.sv
// Shared types, constants and wrap helpers for the scrolling message display.
package msg_display_pkg;

    localparam int CHAR_W     = 5;
    localparam int TICK_CNT_W = 3;

    localparam logic [CHAR_W-1:0] CHAR_BLANK = 5'h1F;

    typedef enum logic [1:0] {
        IDLE,
        SCROLL,
        PAUSE
    } scroll_state_t;

    // Explicit modulo so the message length need not be a power of two.
    function automatic int wrap_inc(input int p, input int len);
        return (p >= len - 1) ? 0 : p + 1;
    endfunction

    function automatic int wrap_dec(input int p, input int len);
        return (p == 0) ? len - 1 : p - 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the display tick down to a scroll step every 2^speed ticks.
module tick_prescaler
    import msg_display_pkg::*;
(
    input  logic       clk_in,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       tick_in,
    input  logic [1:0] speed,
    output logic       step
);

    logic [TICK_CNT_W-1:0] tick_cnt;
    logic [TICK_CNT_W-1:0] limit;

    // The >= compare lets a mid-run speed decrease step on the very next tick.
    assign limit = TICK_CNT_W'((4'd1 << speed) - 4'd1);
    assign step  = en & tick_in & (tick_cnt >= limit);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (en && tick_in) begin
            tick_cnt <= step ? '0 : tick_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/message_scroll_ctrl.sv
// Scroll scheduler: message buffer, scroll position FSM and per-digit character output.
module message_scroll_ctrl
    import msg_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_LEN    = 16,
    parameter int CHAR_W     = msg_display_pkg::CHAR_W,
    parameter int POS_W      = $clog2(MSG_LEN)
)(
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic                         tick_in,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic                         dir,
    input  logic [1:0]                   speed,
    input  logic                         msg_we,
    input  logic [POS_W-1:0]             msg_waddr,
    input  logic [CHAR_W-1:0]            msg_wdata,
    output logic [NUM_DIGITS*CHAR_W-1:0] digit_chars,
    output logic [POS_W-1:0]             pos,
    output logic                         busy,
    output logic                         wrap_pulse
);

    localparam logic [POS_W:0]    LEN_EXT = (POS_W+1)'(MSG_LEN);
    localparam logic [CHAR_W-1:0] BLANK   = CHAR_W'(CHAR_BLANK);

    scroll_state_t                 state;
    logic [CHAR_W-1:0]             msg_buf [MSG_LEN];
    logic [NUM_DIGITS*CHAR_W-1:0]  digits_next;
    logic                          step;
    logic                          clr;
    logic                          en;

    assign clr = stop | (start & (state == IDLE));
    assign en  = (state == SCROLL);

    tick_prescaler u_prescaler (
        .clk_in  (clk_in),
        .reset   (reset),
        .clr     (clr),
        .en      (en),
        .tick_in (tick_in),
        .speed   (speed),
        .step    (step)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pos        <= '0;
            busy       <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (stop) begin
                state <= IDLE;
                pos   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state <= SCROLL;
                        pos   <= '0;
                        busy  <= 1'b1;
                    end
                    SCROLL:  if (pause)  state <= PAUSE;
                    PAUSE:   if (!pause) state <= SCROLL;
                    default: state <= IDLE;
                endcase
                if (step) begin
                    if (dir) begin
                        pos        <= POS_W'(wrap_dec(int'(pos), MSG_LEN));
                        wrap_pulse <= (pos == '0);
                    end else begin
                        pos        <= POS_W'(wrap_inc(int'(pos), MSG_LEN));
                        wrap_pulse <= (pos == POS_W'(MSG_LEN - 1));
                    end
                end
            end
        end
    end

    // NOTE: the buffer is cleared by the async reset on purpose (contents must
    // read as blank after reset), so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= BLANK;
        end else if (msg_we && ({1'b0, msg_waddr} < LEN_EXT)) begin
            msg_buf[msg_waddr] <= msg_wdata;
        end
    end

    // NOTE: digits_next gets a full default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        digits_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (state == IDLE)
                digits_next[(NUM_DIGITS-1-i)*CHAR_W +: CHAR_W] = BLANK;
            else
                digits_next[(NUM_DIGITS-1-i)*CHAR_W +: CHAR_W] =
                    msg_buf[POS_W'((int'(pos) + i) % MSG_LEN)];
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) digit_chars <= {NUM_DIGITS{BLANK}};
        else       digit_chars <= digits_next;
    end

endmodule

// File: tb/tb_message_scroll_ctrl.sv
// Scoreboard bench: stimulus queues expected outputs, a monitor compares them on the falling edge.
module tb_message_scroll_ctrl;

    localparam int ND = 6;
    localparam int ML = 16;
    localparam int CW = 5;
    localparam int PW = 4;

    localparam logic [ND*CW-1:0] BLANK_ALL = {ND{5'h1F}};

    logic              clk_in = 1'b0;
    logic              reset;
    logic              tick_in, start, stop, pause, dir, msg_we;
    logic [1:0]        speed;
    logic [PW-1:0]     msg_waddr;
    logic [CW-1:0]     msg_wdata;
    logic [ND*CW-1:0]  digit_chars;
    logic [PW-1:0]     pos;
    logic              busy, wrap_pulse;

    always #5 clk_in = ~clk_in;

    message_scroll_ctrl #(
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .CHAR_W     (CW),
        .POS_W      (PW)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .tick_in     (tick_in),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .dir         (dir),
        .speed       (speed),
        .msg_we      (msg_we),
        .msg_waddr   (msg_waddr),
        .msg_wdata   (msg_wdata),
        .digit_chars (digit_chars),
        .pos         (pos),
        .busy        (busy),
        .wrap_pulse  (wrap_pulse)
    );

    typedef struct {
        string            name;
        logic [ND*CW-1:0] digits;
        logic [PW-1:0]    pos;
        logic             busy;
        logic             wrap;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Buffer holds char code == address after loading, so a window starting
    // at 'first' shows first, first+1, ... modulo the message length.
    function automatic logic [ND*CW-1:0] window(input int first);
        logic [ND*CW-1:0] d;
        d = '0;
        for (int i = 0; i < ND; i++) d[(ND-1-i)*CW +: CW] = CW'((first + i) % ML);
        return d;
    endfunction

    task automatic expect_out(input string name, input logic [ND*CW-1:0] d,
                              input logic [PW-1:0] p, input logic b, input logic w);
        exp_t e;
        e.name = name; e.digits = d; e.pos = p; e.busy = b; e.wrap = w;
        sb_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk_in);
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, ".digits"}, 32'(digit_chars), 32'(e.digits));
                check({e.name, ".pos"},    32'(pos),         32'(e.pos));
                check({e.name, ".busy"},   32'(busy),        32'(e.busy));
                check({e.name, ".wrap"},   32'(wrap_pulse),  32'(e.wrap));
            end
        end
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic tick_one();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_one();
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; tick_in = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        dir = 1'b0; speed = 2'd0; msg_we = 1'b0; msg_waddr = '0; msg_wdata = '0;
        #2;
        expect_out("reset", BLANK_ALL, 0, 0, 0);
        repeat (2) cyc();
        reset = 1'b0;
        cyc();

        ticks(10);
        expect_out("idle_ticks", BLANK_ALL, 0, 0, 0);

        for (int a = 0; a < ML; a++) begin
            msg_we = 1'b1; msg_waddr = PW'(a); msg_wdata = CW'(a);
            cyc();
        end
        msg_we = 1'b0;
        cyc();
        expect_out("loaded_idle", BLANK_ALL, 0, 0, 0);

        start = 1'b1; cyc(); start = 1'b0;
        expect_out("start", BLANK_ALL, 0, 1, 0);
        cyc();
        expect_out("start_digits", window(0), 0, 1, 0);

        ticks(2);
        tick_one();
        expect_out("left3_pos", window(2), 3, 1, 0);
        cyc();
        expect_out("left3_digits", window(3), 3, 1, 0);

        ticks(11);
        expect_out("pos14", window(14), 14, 1, 0);

        speed = 2'd2;
        ticks(3);
        expect_out("spd2_hold14", window(14), 14, 1, 0);
        tick_one();
        expect_out("spd2_step15", window(14), 15, 1, 0);
        cyc();
        ticks(3);
        expect_out("spd2_hold15", window(15), 15, 1, 0);
        tick_one();
        expect_out("wrap_left", window(15), 0, 1, 1);
        cyc();
        expect_out("wrap_left_after", window(0), 0, 1, 0);

        dir = 1'b1; speed = 2'd0;
        tick_one();
        expect_out("wrap_right", window(0), 15, 1, 1);
        cyc();
        dir = 1'b0;
        tick_one();
        expect_out("dir_flip", window(15), 0, 1, 1);
        cyc();
        expect_out("dir_flip_after", window(0), 0, 1, 0);

        speed = 2'd1;
        tick_one();
        expect_out("cnt_one", window(0), 0, 1, 0);
        pause = 1'b1;
        cyc();
        ticks(20);
        expect_out("paused", window(0), 0, 1, 0);
        pause = 1'b0;
        cyc();
        tick_one();
        expect_out("resume_step", window(0), 1, 1, 0);
        start = 1'b1; cyc(); start = 1'b0;
        expect_out("start_ignored", window(1), 1, 1, 0);

        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        expect_out("start_stop", window(1), 0, 0, 0);
        cyc();
        expect_out("stopped_blank", BLANK_ALL, 0, 0, 0);

        speed = 2'd0;
        start = 1'b1; cyc(); start = 1'b0;
        ticks(7);
        expect_out("pos7", window(7), 7, 1, 0);
        @(posedge clk_in);
        #2;
        reset = 1'b1;
        expect_out("async_reset", BLANK_ALL, 0, 0, 0);
        cyc();
        reset = 1'b0;
        cyc();
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        expect_out("buffer_lost", BLANK_ALL, 0, 1, 0);

        repeat (3) @(negedge clk_in);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, 0 required", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
